ahb_dphase_ctrl: RTL and testbench
==================================

Name: ahb_dphase_ctrl

Overview:
- AHB-Lite address decoder and data-phase response-select controller for the two-slave interconnect.
- Decodes HADDR into per-slave HSEL during the address phase.
- Registers the selection into the data phase to drive the read-data/response mux select (MUX_SEL), holding it across wait states.
- Embeds a default slave that returns the two-cycle ERROR response for active transfers to unmapped addresses.

Parameters:
- ADDR_W, 32, HADDR width.
- REGION_BITS, 12, low address bits ignored by decode (4 KB region per slave).
- S0_BASE, 32'h0000_0000, slave 0 region base; only bits [ADDR_W-1:REGION_BITS] are compared.
- S1_BASE, 32'h0000_1000, slave 1 region base; only bits [ADDR_W-1:REGION_BITS] are compared.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  ADDR_W  address-phase address from master.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  in  1  bus-level ready, fed back from the mux output.
- HSEL_0  out  1  slave 0 select (combinational).
- HSEL_1  out  1  slave 1 select (combinational).
- MUX_SEL  out  1  data-phase select to response mux (0=slave 0, 1=slave 1).
- dflt_active  out  1  data phase belongs to default slave; top level overrides mux HREADYOUT/HRESP with dflt_* and forces HRDATA=0.
- dflt_hreadyout  out  1  default slave HREADYOUT.
- dflt_hresp  out  1  default slave HRESP (0=OKAY, 1=ERROR).

Behaviour:
- Decode (combinational, independent of HTRANS and HREADY):
  - hit0 = HADDR[ADDR_W-1:REGION_BITS] == S0_BASE[ADDR_W-1:REGION_BITS].
  - hit1 = same comparison against S1_BASE, and !hit0. Slave 0 wins on overlap.
  - HSEL_0 = hit0; HSEL_1 = hit1. Unmapped address: neither is asserted.
- Data-phase capture, on a rising edge with HRESETn=1 and HREADY=1:
  - sel_q <= hit1.
  - dflt_q <= !hit0 && !hit1.
  - With HREADY=0, sel_q and dflt_q hold (the wait state extends the data phase).
- Outputs: MUX_SEL = sel_q; dflt_active = dflt_q. Both are registered, with one-cycle latency from address phase to data phase.
- active = HTRANS[1] (NONSEQ or SEQ). IDLE and BUSY are never active.
- Default slave FSM, states D_IDLE, D_ERR1, D_ERR2:
  - D_IDLE: dflt_hreadyout=1, dflt_hresp=0. If HREADY=1, active, and unmapped -> D_ERR1; else stay.
  - D_ERR1: dflt_hreadyout=0, dflt_hresp=1. Unconditionally -> D_ERR2.
  - D_ERR2: dflt_hreadyout=1, dflt_hresp=1. If HREADY=1, active, and unmapped -> D_ERR1 (back-to-back error); else -> D_IDLE.
- Unmapped IDLE/BUSY transfers: dflt_active=1 with a zero-wait OKAY response (FSM stays in D_IDLE).
- Outputs are registered or state-decoded; none depend combinationally on HREADY.
- Reset (HRESETn=0 at an edge), including mid-error: sel_q=0, dflt_q=0, FSM=D_IDLE. So MUX_SEL=0, dflt_active=0, dflt_hreadyout=1, dflt_hresp=0. HSEL_* follow HADDR even during reset.
- A master abandoning the burst after ERR1 (driving IDLE in ERR2) returns the FSM to D_IDLE; the next address is captured normally.

Decomposition:
- Definitions package holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ).
  - dflt_state_t enum (D_IDLE/D_ERR1/D_ERR2).
  - HRESP_OKAY/HRESP_ERROR constants.
  - Default address-map constants S0_BASE/S1_BASE/REGION_BITS.
  - Existing Slave_t is reused by the top level.
- One sub-module is natural: ahb_default_slave, containing the FSM (inputs HCLK, HRESETn, HREADY, err_req; outputs dflt_hreadyout, dflt_hresp).
- Decode and data-phase registers stay in ahb_dphase_ctrl.

Test Plan:
- Reset: HRESETn=0 for 2 cycles, HADDR=32'h0000_1004 -> HSEL_1=1, MUX_SEL=0, dflt_active=0, dflt_hreadyout=1, dflt_hresp=0.
- Pipelined select: NONSEQ 32'h0000_0010 then NONSEQ 32'h0000_1010 with HREADY=1 -> MUX_SEL 0 then 1, each one cycle after its address phase.
- Wait-state hold: NONSEQ 32'h0000_1000, then HREADY=0 for 3 cycles while HADDR=32'h0000_0000 -> MUX_SEL stays 1 all 3 cycles; becomes 0 after HREADY=1.
- Unmapped error: NONSEQ 32'h0000_8000 -> dflt_active=1; next cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1, then D_IDLE on HTRANS=IDLE.
- Back-to-back errors: NONSEQ 32'h0000_8000, then in ERR2 NONSEQ 32'h0000_9000 -> ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between; unmapped IDLE at 32'h0000_8000 -> zero-wait OKAY.
- Reset mid-error: assert HRESETn=0 in D_ERR1 -> next edge dflt_hreadyout=1, dflt_hresp=0, dflt_active=0, MUX_SEL=0.

Source files
------------

// File: rtl/ahb_dphase_ctrl_pkg.sv
// Shared definitions for the two-slave AHB-Lite data-phase controller:
// transfer/response encodings, default slave states and the default address map.
package ahb_dphase_ctrl_pkg;

  // Default address map: two 4 KB regions, low REGION_BITS ignored by decode
  localparam int unsigned REGION_BITS = 12;
  localparam logic [31:0] S0_BASE     = 32'h0000_0000;
  localparam logic [31:0] S1_BASE     = 32'h0000_1000;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } dflt_state_t;

  // Data-phase response mux select
  typedef enum logic {
    SLAVE_0 = 1'b0,
    SLAVE_1 = 1'b1
  } slave_t;

  // Only NONSEQ and SEQ carry a real transfer
  function automatic logic is_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

  // Default slave response per state: {hreadyout, hresp}
  function automatic logic [1:0] dflt_resp(input dflt_state_t s);
    logic [1:0] r;
    case (s)
      D_IDLE:  r = {1'b1, HRESP_OKAY};
      D_ERR1:  r = {1'b0, HRESP_ERROR};
      D_ERR2:  r = {1'b1, HRESP_ERROR};
      default: r = {1'b1, HRESP_OKAY};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_dphase_ctrl_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response (one wait cycle, then ready with ERROR).
module ahb_default_slave (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic HREADY,
  input  logic err_req,
  output logic dflt_hreadyout,
  output logic dflt_hresp
);
  import ahb_dphase_ctrl_pkg::*;

  dflt_state_t state_r;
  dflt_state_t next_s;
  logic        hreadyout_r;
  logic        hresp_r;

  // State register; response flops are loaded from the next state so the
  // outputs are registered yet line up exactly with the state they describe
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r     <= D_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      state_r                <= next_s;
      {hreadyout_r, hresp_r} <= dflt_resp(next_s);
    end
  end

  // Next-state logic: a new error only starts on an accepted address phase
  always_comb begin
    next_s = state_r;
    case (state_r)
      D_IDLE: begin
        if (HREADY && err_req) begin
          next_s = D_ERR1;
        end else begin
          next_s = D_IDLE;
        end
      end
      D_ERR1: begin
        next_s = D_ERR2;
      end
      D_ERR2: begin
        if (HREADY && err_req) begin
          next_s = D_ERR1;
        end else begin
          next_s = D_IDLE;
        end
      end
      default: begin
        next_s = D_IDLE;
      end
    endcase
  end

  assign dflt_hreadyout = hreadyout_r;
  assign dflt_hresp     = hresp_r;

endmodule

// File: rtl/ahb_dphase_ctrl.sv
// AHB-Lite address decoder and data-phase response-select controller for a
// two-slave interconnect, with an embedded default slave for unmapped space.
module ahb_dphase_ctrl #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        REGION_BITS = ahb_dphase_ctrl_pkg::REGION_BITS,
  parameter logic [ADDR_W-1:0]  S0_BASE     = ADDR_W'(ahb_dphase_ctrl_pkg::S0_BASE),
  parameter logic [ADDR_W-1:0]  S1_BASE     = ADDR_W'(ahb_dphase_ctrl_pkg::S1_BASE)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  output logic              HSEL_0,
  output logic              HSEL_1,
  output logic              MUX_SEL,
  output logic              dflt_active,
  output logic              dflt_hreadyout,
  output logic              dflt_hresp
);
  import ahb_dphase_ctrl_pkg::*;

  // Masking keeps the comparison on the region bits only
  localparam logic [ADDR_W-1:0] REGION_MASK = {ADDR_W{1'b1}} << REGION_BITS;

  logic    hit0_s;
  logic    hit1_s;
  logic    unmapped_s;
  logic    active_s;
  logic    err_req_s;
  htrans_t htrans_s;
  slave_t  sel_r;
  logic    dflt_r;

  // Address-phase decode; independent of HTRANS/HREADY, slave 0 wins overlap
  always_comb begin
    htrans_s   = htrans_t'(HTRANS);
    hit0_s     = ((HADDR & REGION_MASK) == (S0_BASE & REGION_MASK));
    hit1_s     = ((HADDR & REGION_MASK) == (S1_BASE & REGION_MASK)) && !hit0_s;
    unmapped_s = !hit0_s && !hit1_s;
    active_s   = is_active(htrans_s);
    err_req_s  = active_s && unmapped_s;
  end

  // Data-phase select registers: advance on accepted address phase, hold in wait states
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_r  <= SLAVE_0;
      dflt_r <= 1'b0;
    end else if (HREADY) begin
      sel_r  <= hit1_s ? SLAVE_1 : SLAVE_0;
      dflt_r <= unmapped_s;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HREADY         (HREADY),
    .err_req        (err_req_s),
    .dflt_hreadyout (dflt_hreadyout),
    .dflt_hresp     (dflt_hresp)
  );

  assign HSEL_0      = hit0_s;
  assign HSEL_1      = hit1_s;
  assign MUX_SEL     = sel_r;
  assign dflt_active = dflt_r;

endmodule

// File: tb/tb_ahb_dphase_ctrl.sv
// Directed self-checking bench for ahb_dphase_ctrl. Data-phase outputs are
// compared as the vector {MUX_SEL, dflt_active, dflt_hreadyout, dflt_hresp}.
module tb_ahb_dphase_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HSEL_0;
  logic        HSEL_1;
  logic        MUX_SEL;
  logic        dflt_active;
  logic        dflt_hreadyout;
  logic        dflt_hresp;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  // Expected {MUX_SEL, dflt_active, dflt_hreadyout, dflt_hresp}
  localparam logic [3:0] E_RST  = 4'b0010;
  localparam logic [3:0] E_S0   = 4'b0010;
  localparam logic [3:0] E_S1   = 4'b1010;
  localparam logic [3:0] E_ERR1 = 4'b0101;
  localparam logic [3:0] E_ERR2 = 4'b0111;
  localparam logic [3:0] E_DOK  = 4'b0110;

  ahb_dphase_ctrl dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HREADY         (HREADY),
    .HSEL_0         (HSEL_0),
    .HSEL_1         (HSEL_1),
    .MUX_SEL        (MUX_SEL),
    .dflt_active    (dflt_active),
    .dflt_hreadyout (dflt_hreadyout),
    .dflt_hresp     (dflt_hresp)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [3:0] obs();
    return {MUX_SEL, dflt_active, dflt_hreadyout, dflt_hresp};
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic rdy);
    HTRANS = t;
    HADDR  = a;
    HREADY = rdy;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(T_NONSEQ, 32'h0000_1004, 1'b1);
    step();
    step();
    checks++;
    if ({HSEL_0, HSEL_1} !== 2'b01) begin
      errors++;
      $display("FAIL reset_hsel got=%b exp=%b", {HSEL_0, HSEL_1}, 2'b01);
    end
    checks++;
    if (obs() !== E_RST) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", obs(), E_RST);
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [7];
    logic [1:0]  exps  [7];
    addrs = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF,
              32'h0000_2000, 32'h8000_1000, 32'hFFFF_FFFF};
    exps  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      drive((i % 2 == 0) ? T_IDLE : T_BUSY, addrs[i], 1'b0);
      #1;
      checks++;
      if ({HSEL_0, HSEL_1} !== exps[i]) begin
        errors++;
        $display("FAIL decode addr=%h got=%b exp=%b", addrs[i], {HSEL_0, HSEL_1}, exps[i]);
      end
    end
    drive(T_IDLE, 32'h0000_0000, 1'b1);
    step();
  endtask

  task automatic test_pipeline();
    drive(T_NONSEQ, 32'h0000_1010, 1'b1);
    step();
    checks++;
    if (obs() !== E_S1) begin
      errors++;
      $display("FAIL pipe_s1_first got=%b exp=%b", obs(), E_S1);
    end
    drive(T_NONSEQ, 32'h0000_0010, 1'b1);
    step();
    checks++;
    if (obs() !== E_S0) begin
      errors++;
      $display("FAIL pipe_s0 got=%b exp=%b", obs(), E_S0);
    end
    drive(T_SEQ, 32'h0000_1FFC, 1'b1);
    step();
    checks++;
    if (obs() !== E_S1) begin
      errors++;
      $display("FAIL pipe_s1 got=%b exp=%b", obs(), E_S1);
    end
  endtask

  task automatic test_wait_hold();
    drive(T_NONSEQ, 32'h0000_1000, 1'b1);
    step();
    drive(T_NONSEQ, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== E_S1) begin
        errors++;
        $display("FAIL wait_hold cycle=%0d got=%b exp=%b", i, obs(), E_S1);
      end
    end
    HREADY = 1'b1;
    step();
    checks++;
    if (obs() !== E_S0) begin
      errors++;
      $display("FAIL wait_release got=%b exp=%b", obs(), E_S0);
    end
  endtask

  task automatic test_error();
    drive(T_NONSEQ, 32'h0000_8000, 1'b1);
    #1;
    checks++;
    if ({HSEL_0, HSEL_1} !== 2'b00) begin
      errors++;
      $display("FAIL err_hsel got=%b exp=%b", {HSEL_0, HSEL_1}, 2'b00);
    end
    step();
    checks++;
    if (obs() !== E_ERR1) begin
      errors++;
      $display("FAIL err_err1 got=%b exp=%b", obs(), E_ERR1);
    end
    drive(T_IDLE, 32'h0000_0000, 1'b0);
    step();
    checks++;
    if (obs() !== E_ERR2) begin
      errors++;
      $display("FAIL err_err2 got=%b exp=%b", obs(), E_ERR2);
    end
    HREADY = 1'b1;
    step();
    checks++;
    if (obs() !== E_S0) begin
      errors++;
      $display("FAIL err_to_idle got=%b exp=%b", obs(), E_S0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [4];
    exp_seq = '{E_ERR1, E_ERR2, E_ERR1, E_ERR2};
    drive(T_NONSEQ, 32'h0000_8000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs() !== exp_seq[i]) begin
        errors++;
        $display("FAIL b2b cycle=%0d got=%b exp=%b", i, obs(), exp_seq[i]);
      end
      // ERR1 stalls the bus; the pending NONSEQ to another hole is accepted in ERR2
      if (i == 0) drive(T_NONSEQ, 32'h0000_9000, 1'b0);
      else if (i == 1) HREADY = 1'b1;
      else if (i == 2) HREADY = 1'b0;
      else drive(T_IDLE, 32'h0000_8000, 1'b1);
    end
    step();
    checks++;
    if (obs() !== E_DOK) begin
      errors++;
      $display("FAIL b2b_idle_unmapped got=%b exp=%b", obs(), E_DOK);
    end
    drive(T_BUSY, 32'h0000_8000, 1'b1);
    step();
    checks++;
    if (obs() !== E_DOK) begin
      errors++;
      $display("FAIL busy_unmapped got=%b exp=%b", obs(), E_DOK);
    end
    drive(T_IDLE, 32'h0000_0000, 1'b1);
    step();
    checks++;
    if (obs() !== E_S0) begin
      errors++;
      $display("FAIL b2b_recover got=%b exp=%b", obs(), E_S0);
    end
  endtask

  task automatic test_reset_mid_error();
    drive(T_NONSEQ, 32'h0000_8000, 1'b1);
    step();
    checks++;
    if (obs() !== E_ERR1) begin
      errors++;
      $display("FAIL rst_mid_err1 got=%b exp=%b", obs(), E_ERR1);
    end
    HRESETn = 1'b0;
    drive(T_NONSEQ, 32'h0000_1000, 1'b0);
    step();
    checks++;
    if (obs() !== E_RST) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b exp=%b", obs(), E_RST);
    end
    HRESETn = 1'b1;
    drive(T_NONSEQ, 32'h0000_1004, 1'b1);
    step();
    checks++;
    if (obs() !== E_S1) begin
      errors++;
      $display("FAIL rst_mid_resume got=%b exp=%b", obs(), E_S1);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(T_IDLE, 32'h0000_0000, 1'b1);
    test_reset();
    test_decode();
    test_pipeline();
    test_wait_hold();
    test_error();
    test_back_to_back();
    test_reset_mid_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
